mem_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the fetch stage (instruction reads) and the load/store unit (data reads/writes).
- Data side has priority. A starvation counter guarantees fetch progress.
- Inst side has a flush input that drops an in-flight fetch response, so a branch/jump never receives a stale instruction.
- One outstanding memory transaction at a time. Memory command outputs are registered.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and LSU.
// Data side has priority; a streak counter guarantees fetch progress.
// Ports: clk, rst_n (async, active low)
//   inst_*  : fetch req/addr/flush in, gnt/rvalid/rdata out
//   data_*  : LSU req/we/be/addr/wdata in, gnt/rvalid/rdata out
//   mem_*   : registered command out, rvalid/rdata response in
module mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE_I = 3'd1;
  localparam logic [2:0] ISSUE_D = 3'd2;
  localparam logic [2:0] WAIT_I  = 3'd3;
  localparam logic [2:0] WAIT_D  = 3'd4;

  localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

  logic [2:0]  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        drop_q, drop_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic idle;
  logic data_win;
  logic inst_win;

  assign idle     = (state_q == IDLE);
  // Data loses only when fetch is waiting and the streak is exhausted.
  assign data_win = idle & data_req & (~inst_req | (streak_q < MAX_S));
  assign inst_win = idle & inst_req & ~data_win;

  assign inst_gnt = rst_n & inst_win;
  assign data_gnt = rst_n & data_win;

  // A flush in the response cycle itself also suppresses the pulse.
  assign inst_rvalid = rst_n & (state_q == WAIT_I) & mem_rvalid
                     & ~drop_q & ~inst_flush;
  assign data_rvalid = rst_n & (state_q == WAIT_D) & mem_rvalid;
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          data_win: state_d = ISSUE_D;
          inst_win: state_d = ISSUE_I;
          default:  state_d = IDLE;
        endcase
      end
      ISSUE_I: state_d = WAIT_I;
      ISSUE_D: state_d = WAIT_D;
      WAIT_I:  state_d = mem_rvalid ? IDLE : WAIT_I;
      WAIT_D:  state_d = mem_rvalid ? IDLE : WAIT_D;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (data_win) begin
      if (!inst_req)
        streak_d = 4'd0;
      else if (streak_q < MAX_S)
        streak_d = streak_q + 4'd1;
    end else if (inst_win) begin
      streak_d = 4'd0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (state_q == WAIT_I && mem_rvalid)
      drop_d = 1'b0;
    else if (inst_flush && (inst_win || state_q == ISSUE_I
                            || state_q == WAIT_I))
      drop_d = 1'b1;
  end

  always_comb begin
    req_d   = data_win | inst_win;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      data_win: begin
        we_d    = data_we;
        be_d    = data_be;
        addr_d  = data_addr;
        wdata_d = data_wdata;
      end
      inst_win: begin
        we_d    = 1'b0;
        be_d    = 4'hF;
        addr_d  = inst_addr;
        wdata_d = 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Memory model with configurable latency; monitor pops expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_flush = 1'b0;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_flush(inst_flush), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        inst;
    logic [31:0] d;
    logic        cmp;
  } rsp_t;

  cmd_t cmdq[$];
  rsp_t rspq[$];
  logic [31:0] mem [logic [31:0]];

  int errors = 0;
  int checks = 0;
  int lat = 2;
  int n_irv = 0;
  int n_drv = 0;
  int drv_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory model: captures a command on mem_req, answers after lat.
  logic [31:0] ma, md;
  int ml;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        ma = mem_addr;
        ml = lat;
        md = rd(ma);
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) md[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[ma] = md;
        end
        repeat (ml) @(posedge clk);
        #1 mem_rvalid = 1'b1;
        mem_rdata = md;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  // Monitor: checks commands and responses against the queues.
  cmd_t c;
  rsp_t r;
  initial forever begin
    @(negedge clk);
    if (rst_n && mem_req) begin
      if (cmdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmd: got addr %0h expected none",
                 mem_addr);
      end else begin
        c = cmdq.pop_front();
        chk("cmd_addr", mem_addr, c.addr);
        chk("cmd_webe", {27'h0, mem_we, mem_be}, {27'h0, c.we, c.be});
        chk("cmd_wdata", mem_wdata, c.wdata);
      end
    end
    if (inst_rvalid) n_irv++;
    if (data_rvalid) begin
      n_drv++;
      drv_cyc = cyc;
    end
    if (inst_rvalid || data_rvalid) begin
      if (rspq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got i=%0b d=%0b expected none",
                 inst_rvalid, data_rvalid);
      end else begin
        r = rspq.pop_front();
        chk("rsp_kind", {30'h0, inst_rvalid, data_rvalid},
            {30'h0, r.inst, ~r.inst});
        if (r.cmp)
          chk("rsp_data", inst_rvalid ? inst_rdata : data_rdata, r.d);
      end
    end
  end

  task automatic push_i(input logic [31:0] a, input logic [31:0] d);
    cmdq.push_back({a, 1'b0, 4'hF, 32'h0});
    rspq.push_back({1'b1, d, 1'b1});
  endtask

  task automatic push_d(input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] d, input logic cmp);
    cmdq.push_back({a, we, be, wd});
    rspq.push_back({1'b0, d, cmp});
  endtask

  task automatic wait_gnt(input bit inst);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (inst ? inst_gnt : data_gnt) return;
    end
    checks++; errors++;
    $display("FAIL gnt_timeout: got no grant expected inst=%0b", inst);
  endtask

  task automatic issue_i(input logic [31:0] a, input logic fl);
    inst_addr  = a;
    inst_req   = 1'b1;
    inst_flush = fl;
    wait_gnt(1'b1);
    @(posedge clk);
    #1 inst_req = 1'b0;
    inst_flush = 1'b0;
  endtask

  task automatic issue_d(input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    data_we    = we;
    data_be    = be;
    data_addr  = a;
    data_wdata = wd;
    data_req   = 1'b1;
    wait_gnt(1'b0);
    @(posedge clk);
    #1 data_req = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (rspq.size() == 0 && cmdq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(rspq.size() + cmdq.size()), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  bit exp_seq [6];
  bit got_seq [6];
  int g;
  int k;

  initial begin
    mem[32'h100]  = 32'h00500093;
    mem[32'h104]  = 32'h00000013;
    mem[32'h40]   = 32'h00A00113;
    mem[32'h2000] = 32'hCAFE0001;
    mem[32'h3000] = 32'h11223344;

    // Requests held during reset must not be granted.
    inst_req = 1'b1;
    data_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_inst_gnt", 32'(inst_gnt), 32'h0);
    chk("rst_data_gnt", 32'(data_gnt), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1 inst_req = 1'b0;
    data_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, latency 2.
    push_i(32'h100, 32'h00500093);
    inst_addr = 32'h100;
    inst_req  = 1'b1;
    @(negedge clk);
    chk("f_inst_gnt", 32'(inst_gnt), 32'h1);
    chk("f_data_gnt", 32'(data_gnt), 32'h0);
    @(posedge clk);
    #1 inst_req = 1'b0;
    @(negedge clk);
    chk("f_t1_req", 32'(mem_req), 32'h1);
    chk("f_t1_be", 32'(mem_be), 32'hF);
    @(negedge clk);
    chk("f_t2_req", 32'(mem_req), 32'h0);
    chk("f_t2_addr", mem_addr, 32'h100);
    chk("f_t2_rv", 32'(inst_rvalid), 32'h0);
    @(negedge clk);
    chk("f_t3_rv", 32'(inst_rvalid), 32'h1);
    chk("f_t3_rdata", inst_rdata, 32'h00500093);
    @(negedge clk);
    chk("f_t4_rv", 32'(inst_rvalid), 32'h0);
    drain();

    // Simultaneous requests: data first, inst right after data_rvalid.
    push_d(1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE0001, 1'b1);
    push_i(32'h104, 32'h00000013);
    data_we   = 1'b0;
    data_be   = 4'hF;
    data_addr = 32'h2000;
    data_req  = 1'b1;
    inst_addr = 32'h104;
    inst_req  = 1'b1;
    @(negedge clk);
    chk("sim_data_gnt", 32'(data_gnt), 32'h1);
    chk("sim_inst_gnt", 32'(inst_gnt), 32'h0);
    @(posedge clk);
    #1 data_req = 1'b0;
    wait_gnt(1'b1);
    chk("sim_turnaround", 32'(cyc), 32'(drv_cyc + 1));
    @(posedge clk);
    #1 inst_req = 1'b0;
    drain();

    // Partial write, then read back the merged word.
    push_d(1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF, 32'h0, 1'b0);
    issue_d(1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF);
    drain();
    push_d(1'b0, 4'hF, 32'h3000, 32'h0, 32'h1122BEEF, 1'b1);
    issue_d(1'b0, 4'hF, 32'h3000, 32'h0);
    drain();

    // Flush while waiting, then flush in the grant cycle.
    k = n_irv;
    cmdq.push_back({32'h100, 1'b0, 4'hF, 32'h0});
    issue_i(32'h100, 1'b0);
    @(posedge clk);
    #1 inst_flush = 1'b1;
    @(posedge clk);
    #1 inst_flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_wait", 32'(n_irv), 32'(k));
    cmdq.push_back({32'h100, 1'b0, 4'hF, 32'h0});
    issue_i(32'h100, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_gnt", 32'(n_irv), 32'(k));
    push_i(32'h40, 32'h00A00113);
    issue_i(32'h40, 1'b0);
    drain();
    chk("flush_target", 32'(n_irv), 32'(k + 1));

    // Reset in WAIT_D with a streak of 1; late response is ignored.
    lat = 5;
    cmdq.push_back({32'h2000, 1'b0, 4'hF, 32'h0});
    data_we   = 1'b0;
    data_be   = 4'hF;
    data_addr = 32'h2000;
    data_req  = 1'b1;
    inst_addr = 32'h104;
    inst_req  = 1'b1;
    wait_gnt(1'b0);
    @(posedge clk);
    #1 data_req = 1'b0;
    inst_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    k = n_drv;
    @(negedge clk);
    chk("rstmid_req", 32'(mem_req), 32'h0);
    chk("rstmid_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rstmid_no_rv", 32'(n_drv), 32'(k));
    lat = 2;

    // Starvation: both held, streak starts at 0 after reset.
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (exp_seq[i])
        push_i(32'h104, 32'h00000013);
      else
        push_d(1'b0, 4'hF, 32'h2000, 32'h0, 32'hCAFE0001, 1'b1);
    end
    data_we   = 1'b0;
    data_be   = 4'hF;
    data_addr = 32'h2000;
    inst_addr = 32'h104;
    data_req  = 1'b1;
    inst_req  = 1'b1;
    g = 0;
    for (int n = 0; n < 400 && g < 6; n++) begin
      @(negedge clk);
      if (data_gnt || inst_gnt) begin
        got_seq[g] = inst_gnt;
        g++;
      end
    end
    @(posedge clk);
    #1 data_req = 1'b0;
    inst_req = 1'b0;
    chk("starve_count", 32'(g), 32'h6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("starve_%0d", i), 32'(got_seq[i]),
          32'(exp_seq[i]));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
